argmax: RTL and testbench

- Sequential arg-max unit: after a start pulse, scans a vector of DIM signed values one element per clock.
- Reports the index of the largest element, with ties resolved to the lowest index.
- Sits at the classifier output of the CNN datapath; converts the final-layer score vector into a predicted class index.
- Single clock domain; start/done pulse handshake.

---
 rtl/argmax.sv | 96 +++++++++
 tb/tb_argmax.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/argmax.sv
// Sequential arg-max: after a start pulse, walks a latched copy of the
// input vector one element per clock and reports the index of the first
// (lowest-index) maximum as a one-cycle done pulse with a held index.
module argmax #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
    output logic        [IDXW-1:0]       idx,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0] FIRST_CNT = IDXW'(1);

    state_t                       state_reg;
    logic signed [DATA_WIDTH-1:0] copy_reg [0:DIM-1];
    logic signed [DATA_WIDTH-1:0] best_reg;
    logic        [IDXW-1:0]       best_idx_reg;
    logic        [IDXW-1:0]       counter_reg;
    logic                         load;
    logic signed [DATA_WIDTH-1:0] cur_elem;

    // A scan is accepted only from IDLE, and reset wins over start.
    assign load = (state_reg == IDLE) && start && !reset;

    // Element under test this cycle; counter never exceeds DIM-1 while scanning.
    assign cur_elem = copy_reg[counter_reg];

    // Snapshot the whole vector at start so later input changes are ignored.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_copy
            always_ff @(posedge clk) begin
                if (load) begin
                    copy_reg[gi] <= vec[gi];
                end
            end
        end
    endgenerate

    // Control FSM with the running best value/index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            best_reg     <= '0;
            best_idx_reg <= '0;
            counter_reg  <= '0;
            idx          <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        best_reg     <= vec[0];
                        best_idx_reg <= '0;
                        counter_reg  <= FIRST_CNT;
                        state_reg    <= (DIM == 1) ? FINISH : SCAN;
                    end
                end
                SCAN: begin
                    // Strictly greater only: an equal later element never
                    // displaces the earlier one, so the first maximum wins.
                    if (cur_elem > best_reg) begin
                        best_reg     <= cur_elem;
                        best_idx_reg <= counter_reg;
                    end
                    if (counter_reg == LAST_IDX) begin
                        state_reg <= FINISH;
                    end else begin
                        counter_reg <= counter_reg + FIRST_CNT;
                    end
                end
                FINISH: begin
                    idx       <= best_idx_reg;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax.sv
// Directed bench for argmax with DIM=6: checks reset state, latency,
// tie-breaking, signed extremes, back-to-back scans, input latching,
// ignored mid-scan starts and reset abort.
module tb_argmax;

    localparam int DW  = 16;
    localparam int DIM = 6;
    localparam int IW  = 3;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic signed [DW-1:0] vec [0:DIM-1];
    logic        [IW-1:0] idx;
    logic                 done;

    int errors;
    int checks;
    int pulses;

    argmax #(
        .DATA_WIDTH(DW),
        .DIM       (DIM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .vec  (vec),
        .idx  (idx),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int a, input int b, input int c,
                           input int d, input int e, input int f);
        vec[0] = DW'(a);
        vec[1] = DW'(b);
        vec[2] = DW'(c);
        vec[3] = DW'(d);
        vec[4] = DW'(e);
        vec[5] = DW'(f);
    endtask

    // Pulse start for one edge; returns #1 after the edge that sampled it.
    task automatic start_scan();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; expects it on the 6th edge after the start edge.
    task automatic wait_done(input int elapsed, input int exp_idx, input string tag);
        int k;
        k = elapsed;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, k, DIM);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_idx"}, {29'd0, idx}, exp_idx);
        $display("scan %s: idx=%0d after %0d cycles", tag, idx, k);
    endtask

    task automatic count_pulses(input int cycles);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        set_vec(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_idx", {29'd0, idx}, 0);
        check("reset_done", {31'd0, done}, 0);

        // Tie between indices 1 and 3; the first one wins.
        set_vec(-3, -1, -7, -1, -2, -9);
        start_scan();
        wait_done(0, 1, "tie_neg");
        @(posedge clk);
        #1;
        check("tie_neg_done_drop", {31'd0, done}, 0);
        check("tie_neg_idx_hold", {29'd0, idx}, 1);

        set_vec(0, 5, 2, 5, 1, 4);
        start_scan();
        wait_done(0, 1, "tie_pos");

        // Back-to-back: restart in the cycle done is high.
        @(posedge clk);
        #1;
        set_vec(1, 2, 3, 9, 8, 0);
        start_scan();
        wait_done(0, 3, "mid_max");
        set_vec(7, 0, 0, 0, 0, 8);
        start_scan();
        wait_done(0, 5, "b2b_last");

        // Signed extremes.
        set_vec(-32768, -32768, -32768, -32768, -32768, -32768);
        start_scan();
        wait_done(0, 0, "all_min");
        set_vec(-32768, 32767, 0, 0, 0, 0);
        start_scan();
        wait_done(0, 1, "extremes");

        // Input changes after start and a second start mid-scan are ignored.
        set_vec(1, 2, 3, 4, 5, 2);
        start_scan();
        set_vec(9, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, 4, "latched");
        count_pulses(10);
        check("latched_extra_pulses", pulses, 0);

        // Reset three cycles into a scan aborts it.
        set_vec(0, 0, 0, 0, 0, 7);
        start_scan();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_idx", {29'd0, idx}, 0);
        check("abort_done", {31'd0, done}, 0);
        count_pulses(10);
        check("abort_pulses", pulses, 0);
        $display("abort: idx=%0d pulses=%0d", idx, pulses);

        set_vec(5, 9, 2, 6, 5, 3);
        start_scan();
        wait_done(0, 1, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
